stat_resp_misr: RTL and testbench

//   Response-side reader for the generated Stat_* combinational benchmarks.

---
 rtl/stat_resp_misr.sv | 123 ++++++++++++
 tb/tb_stat_resp_misr.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_resp_misr.sv
// Response-side MISR compactor for the Stat_* benchmarks: folds NVEC response
// vectors into a signature and compares the final value against a golden one.
module stat_resp_misr #(
  parameter int                WIDTH = 24,
  parameter logic [WIDTH-1:0]  POLY  = 24'hC20001,
  parameter logic [WIDTH-1:0]  SEED  = 24'h000000,
  parameter int                NVEC  = 256,
  parameter int                CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] golden,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  logic [WIDTH-1:0] resp_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] vec_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NVEC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // One MISR clock: shift left, fold the dropped MSB back through POLY, mix in data.
  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] fb;
    fb        = s[WIDTH-1] ? POLY : {WIDTH{1'b0}};
    misr_step = {s[WIDTH-2:0], 1'b0} ^ fb ^ d;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic             beat_s;
  logic             last_s;
  logic             restart_s;
  logic [WIDTH-1:0] sig_s;

  // Next-state decode; abort overrides everything, start is ignored while running.
  always_comb begin
    state_s   = state_r;
    restart_s = 1'b0;
    beat_s    = resp_valid & resp_ready;
    last_s    = (vec_count == LAST_CNT);
    sig_s     = misr_step(signature, resp_data);
    if (abort) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_s   = RUN;
            restart_s = 1'b1;
          end else begin
            state_s = state_r;
          end
        end
        RUN: begin
          if (beat_s && last_s) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Status flags are decoded from the next state so they line up with state_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      resp_ready <= (state_s == RUN);
      busy       <= (state_s == RUN);
      done       <= (state_s == DONE);
    end
  end

  // Signature datapath; abort keeps signature and count visible for debug.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signature <= SEED;
      vec_count <= {CNT_W{1'b0}};
      pass      <= 1'b0;
    end else if (abort) begin
      pass <= 1'b0;
    end else if (restart_s) begin
      signature <= SEED;
      vec_count <= {CNT_W{1'b0}};
      pass      <= 1'b0;
    end else if (beat_s) begin
      signature <= sig_s;
      vec_count <= vec_count + CNT_ONE;
      if (last_s) begin
        pass <= (sig_s == golden);
      end
    end
  end

endmodule

// File: tb/tb_stat_resp_misr.sv
// Self-checking bench for stat_resp_misr: four instances with different NVEC/SEED,
// checked against a polynomial-arithmetic reference model.
module tb_stat_resp_misr;

  localparam int W = 24;
  localparam int C = 16;

  function automatic int nv_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
  endfunction

  function automatic logic [W-1:0] seed_of(input int g);
    return (g == 3) ? 24'h5A5A5A : 24'h000000;
  endfunction

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   start = 4'b0, abort = 4'b0, valid = 4'b0;
  logic [3:0]   ready, busy, done, pass;
  logic [W-1:0] data   [4];
  logic [W-1:0] golden [4];
  logic [W-1:0] sig    [4];
  logic [C-1:0] cnt    [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    stat_resp_misr #(.NVEC(nv_of(g)), .SEED(seed_of(g))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start[g]),
      .abort     (abort[g]),
      .golden    (golden[g]),
      .resp_valid(valid[g]),
      .resp_ready(ready[g]),
      .resp_data (data[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .pass      (pass[g]),
      .signature (sig[g]),
      .vec_count (cnt[g])
    );
  end

  // Reference: signature after k vectors = seed*x^k + sum d_i*x^(k-1-i) mod P(x),
  // P(x) = x^24+x^23+x^22+x^17+1.
  function automatic logic [W-1:0] mulx(input logic [W-1:0] a);
    logic [W:0] t;
    t = {a, 1'b0};
    if (t[W]) t = t ^ 25'h1C20001;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] times_xpow(input logic [W-1:0] a, input int k);
    logic [W-1:0] r;
    r = a;
    for (int i = 0; i < k; i++) r = mulx(r);
    return r;
  endfunction

  function automatic logic [W-1:0] model_sig(input logic [W-1:0] seed,
                                             input logic [W-1:0] q[$], input int k);
    logic [W-1:0] r;
    r = times_xpow(seed, k);
    for (int i = 0; i < k; i++) r = r ^ times_xpow(q[i], k - 1 - i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int u);
    start[u] = 1'b1;
    tick();
    start[u] = 1'b0;
  endtask

  task automatic drive(input int u, input logic v, input logic [W-1:0] d);
    valid[u] = v;
    data[u]  = d;
    tick();
    valid[u] = 1'b0;
  endtask

  // Full run with random data; mode 0 = valid pattern 1,0,0,..., mode 1 = random valid.
  task automatic do_run(input int u, input int mode, input bit good);
    logic [W-1:0] dl[$];
    int k, cyc, nv;
    logic v;
    nv = nv_of(u);
    for (int i = 0; i < nv; i++) dl.push_back(W'($urandom));
    golden[u] = good ? model_sig(seed_of(u), dl, nv) : model_sig(seed_of(u), dl, nv) ^ 24'h000100;
    pulse_start(u);
    chk("run_busy", busy[u], 1);
    chk("run_ready", ready[u], 1);
    chk("run_done_clr", done[u], 0);
    chk("run_seed", sig[u], seed_of(u));
    chk("run_cnt0", cnt[u], 0);
    k = 0;
    cyc = 0;
    while (k < nv && cyc < 200) begin
      v = (mode == 0) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      valid[u] = v;
      data[u]  = v ? dl[k] : W'($urandom);
      tick();
      if (v) k++;
      chk("run_sig", sig[u], model_sig(seed_of(u), dl, k));
      chk("run_cnt", cnt[u], k);
      chk("run_done", done[u], (k == nv));
      chk("run_rdy", ready[u], (k < nv));
      cyc++;
    end
    valid[u] = 1'b0;
    if (k < nv) chk("run_timeout", 0, 1);
    chk("run_pass", pass[u], good);
  endtask

  initial begin
    logic [W-1:0] q[$];
    for (int i = 0; i < 4; i++) begin
      data[i]   = 24'h000000;
      golden[i] = 24'h000000;
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rst_ready", ready[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_done", done[i], 0);
      chk("rst_pass", pass[i], 0);
      chk("rst_sig", sig[i], seed_of(i));
      chk("rst_cnt", cnt[i], 0);
    end

    // NVEC=1: a single beat finishes the run; no beat in the following cycle.
    pulse_start(0);
    chk("t1_busy", busy[0], 1);
    valid[0] = 1'b1;
    data[0]  = 24'h000001;
    tick();
    chk("t1_sig", sig[0], 24'h000001);
    chk("t1_cnt", cnt[0], 1);
    chk("t1_done", done[0], 1);
    chk("t1_ready", ready[0], 0);
    chk("t1_pass", pass[0], 0);
    data[0] = 24'h123456;
    tick();
    valid[0] = 1'b0;
    chk("t1_hold_cnt", cnt[0], 1);
    chk("t1_hold_sig", sig[0], 24'h000001);

    // NVEC=2: feedback path; then restart from DONE with the same data.
    golden[1] = 24'hC20001;
    pulse_start(1);
    drive(1, 1'b1, 24'h800000);
    chk("t2_sig1", sig[1], 24'h800000);
    chk("t2_done1", done[1], 0);
    drive(1, 1'b1, 24'h000000);
    chk("t2_sig2", sig[1], 24'hC20001);
    chk("t2_done2", done[1], 1);
    chk("t2_pass", pass[1], 1);
    golden[1] = 24'h000000;
    pulse_start(1);
    chk("t6_busy", busy[1], 1);
    chk("t6_sig", sig[1], 24'h000000);
    chk("t6_cnt", cnt[1], 0);
    chk("t6_pass_clr", pass[1], 0);
    drive(1, 1'b1, 24'h800000);
    drive(1, 1'b1, 24'h000000);
    chk("t6_sig2", sig[1], 24'hC20001);
    chk("t6_fail", pass[1], 0);

    // NVEC=4 with backpressure pattern.
    do_run(2, 0, 1'b1);

    // Abort after 2 of 4 beats; a start during RUN is ignored.
    q.delete();
    pulse_start(2);
    q.push_back(W'($urandom));
    drive(2, 1'b1, q[0]);
    q.push_back(W'($urandom));
    start[2] = 1'b1;
    drive(2, 1'b1, q[1]);
    start[2] = 1'b0;
    chk("t4_cnt_run", cnt[2], 2);
    abort[2] = 1'b1;
    tick();
    abort[2] = 1'b0;
    chk("t4_busy", busy[2], 0);
    chk("t4_ready", ready[2], 0);
    chk("t4_cnt", cnt[2], 2);
    chk("t4_sig", sig[2], model_sig(24'h000000, q, 2));
    chk("t4_done", done[2], 0);
    drive(2, 1'b1, 24'hFFFFFF);
    chk("t4_idle_cnt", cnt[2], 2);
    start[2] = 1'b1;
    abort[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    abort[2] = 1'b0;
    chk("t4_abort_wins", busy[2], 0);
    pulse_start(2);
    chk("t4_restart_sig", sig[2], 24'h000000);
    chk("t4_restart_cnt", cnt[2], 0);

    // NVEC=16, non-zero seed, random valid; back-to-back from DONE with wrong golden.
    do_run(3, 1, 1'b1);
    do_run(3, 1, 1'b0);

    // Asynchronous reset mid-run.
    pulse_start(3);
    drive(3, 1'b1, 24'hABCDEF);
    drive(3, 1'b1, 24'h13579B);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_sig", sig[3], seed_of(3));
    chk("t5_cnt", cnt[3], 0);
    chk("t5_busy", busy[3], 0);
    chk("t5_ready", ready[3], 0);
    chk("t5_busy2", busy[2], 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t5_idle", busy[3], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
